mmss_seconds_counter: RTL and testbench
=======================================

// Module: mmss_seconds_counter
// PURPOSE
//  Consumes the 1 Hz square wave driven by the one-hertz LED divider and turns
//  it into a BCD minutes:seconds count (00:00..59:59) for the 7-segment display path.
//  Rising edge of the wave = one second. Run/pause and clear controls come from
//  debounced board switches. Downstream is the display mux/decoder.
// PARAMETERS
//  MIN_MODULUS  60  minutes wrap value; legal 1..100; count wraps (MIN_MODULUS-1):59 -> 00:00
// PORTS
//  clk        in   1  system clock; the only clock in the block
//  rst        in   1  synchronous, active-high reset
//  sec_wave   in   1  1 Hz square wave from the LED divider, same clock domain
//  run        in   1  level; 1 = count seconds, 0 = paused
//  clr        in   1  level; 1 = force count to 00:00
//  sec_ones   out  4  BCD seconds units, 0..9
//  sec_tens   out  4  BCD seconds tens, 0..5
//  min_ones   out  4  BCD minutes units, 0..9
//  min_tens   out  4  BCD minutes tens, 0..9
//  sec_tick   out  1  1-cycle pulse, coincident with each accepted second increment
//  rollover   out  1  1-cycle pulse, coincident with wrap from last value to 00:00
// BEHAVIOUR
//  - Reset: all digits 0, sec_tick=0, rollover=0, edge register wave_q=1.
//    Every register is clocked; rst is sampled only on the clk edge.
//  - wave_q <= sec_wave every cycle, including while paused or clearing.
//  - edge = sec_wave & ~wave_q. wave_q resets to 1, so a wave that is already
//    high when reset is released does not count as an edge.
//  - accept = edge & run & ~clr. On an accepted cycle the digits and sec_tick
//    update at that same clk edge. Outputs change 1 cycle after sec_wave is
//    sampled high. The block holds no other latency stages.
//  - Priority per cycle: rst > clr > accept > hold.
//  - clr: digits <= 0. sec_tick=0 and rollover=0 in that cycle.
//  - Edges that arrive while run=0 or clr=1 are dropped, not queued.
//    Resuming while sec_wave is high does not produce a spurious count.
//  - Increment chain (ripple carry, single cycle):
//      sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into minutes.
//      Minutes count as a BCD pair modulo MIN_MODULUS.
//      At (MIN_MODULUS-1):59 all four digits -> 0 and rollover=1 with sec_tick=1.
//  - sec_tick and rollover are registered, high for exactly one cycle, else 0.
//  - Digits never take an illegal BCD value. sec_tens never exceeds 5.
//  - Reset mid-count returns to 00:00 on the next edge. The first count after that
//    needs a fresh low->high transition of sec_wave.
//  - No state machine beyond the edge register. The counter chain is the state.
// STRUCTURE
//  - Shared defines file clock_defs.vh holds:
//      BCD_W=4, SEC_TENS_MAX=5, DIGIT_MAX=9, DEFAULT_MIN_MODULUS=60.
//  - Sub-module bcd_digit:
//      parameters MAX (wrap value), plus an optional terminal override input.
//      ports clk, rst, clr, inc, q[3:0], carry.
//      carry = inc & (q==MAX or override).
//  - Top level: edge detect + 4 x bcd_digit + minute-modulus terminal compare
//    + registered sec_tick/rollover.
// TESTING
//  Bench: clk period 10 ns. sec_wave is driven by the bench with a short period
//  (e.g. 20 cycles) so runs stay short. Scenarios:
//  1. rst=1 for 3 cycles with sec_wave=1, then run=1 and hold sec_wave=1
//     -> digits stay 00:00 and sec_tick never pulses.
//  2. run=1, apply 10 rising edges -> 00:10, 10 single-cycle sec_tick pulses,
//     each pulse 1 cycle after the edge is sampled.
//  3. Preload to 00:59 via 59 edges, then 1 more edge
//     -> 01:00 in one cycle with no intermediate value.
//  4. Reach 59:59 (3599 edges), then 1 edge -> 00:00, rollover=1 and sec_tick=1
//     for one cycle. With MIN_MODULUS=2: 01:59 -> 00:00 instead.
//  5. run=0 across 5 edges -> count frozen. Set run=1 while sec_wave is high
//     -> no count until the next rising edge.
//  6. clr=1 on the same cycle as an edge at 00:42 -> 00:00, sec_tick=0.
//     rst asserted mid-count at 12:34 -> 00:00 at the next clk edge.

Source files
------------

// File: rtl/mmss_seconds_counter_pkg.sv
// Shared constants and helpers for the MM:SS seconds counter.
package mmss_seconds_counter_pkg;

  localparam int BCD_W               = 4;
  localparam int SEC_TENS_MAX        = 5;
  localparam int DIGIT_MAX           = 9;
  localparam int DEFAULT_MIN_MODULUS = 60;

  // Last legal minute value as a BCD pair {tens, ones}, e.g. 60 -> 8'h59.
  function automatic logic [2*BCD_W-1:0] min_terminal_bcd(input int modulus);
    int last;
    last = modulus - 1;
    return {BCD_W'(last / 10), BCD_W'(last % 10)};
  endfunction

endpackage

// File: rtl/mmss_seconds_counter_bcd_digit.sv
// One BCD counter digit with wrap at MAX or on an external terminal override.
module bcd_digit
  import mmss_seconds_counter_pkg::*;
#(
  parameter int MAX = DIGIT_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             term_ovr,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  localparam logic [BCD_W-1:0] MAX_V = BCD_W'(MAX);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;
  logic             at_term;

  always_comb begin
    at_term = (q_q == MAX_V) | term_ovr;
    carry   = inc & at_term;
    q_d     = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = at_term ? '0 : q_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mmss_seconds_counter.sv
// BCD minutes:seconds counter advanced by rising edges of a 1 Hz wave.
module mmss_seconds_counter
  import mmss_seconds_counter_pkg::*;
#(
  parameter int MIN_MODULUS = DEFAULT_MIN_MODULUS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sec_wave,
  input  logic             run,
  input  logic             clr,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] min_tens,
  output logic             sec_tick,
  output logic             rollover
);

  localparam logic [2*BCD_W-1:0] MIN_TERM = min_terminal_bcd(MIN_MODULUS);

  logic wave_q, wave_d;
  logic tick_q, tick_d;
  logic rollover_q, rollover_d;
  logic sec_edge, accept, min_term;
  logic so_carry, st_carry, mo_carry, mt_carry;

  // wave_q resets high so a wave already high at reset release is not an edge.
  always_comb begin
    wave_d     = sec_wave;
    sec_edge   = sec_wave & ~wave_q;
    accept     = sec_edge & run & ~clr;
    min_term   = (min_tens == MIN_TERM[2*BCD_W-1:BCD_W]) &&
                 (min_ones == MIN_TERM[BCD_W-1:0]);
    tick_d     = accept;
    rollover_d = mt_carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wave_q     <= 1'b1;
      tick_q     <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      wave_q     <= wave_d;
      tick_q     <= tick_d;
      rollover_q <= rollover_d;
    end
  end

  bcd_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
    .clk(clk), .rst(rst), .clr(clr), .inc(accept), .term_ovr(1'b0),
    .q(sec_ones), .carry(so_carry)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(clr), .inc(so_carry), .term_ovr(1'b0),
    .q(sec_tens), .carry(st_carry)
  );

  // Both minute digits wrap together when the pair hits MIN_MODULUS-1.
  bcd_digit #(.MAX(DIGIT_MAX)) u_min_ones (
    .clk(clk), .rst(rst), .clr(clr), .inc(st_carry), .term_ovr(min_term),
    .q(min_ones), .carry(mo_carry)
  );

  bcd_digit #(.MAX(DIGIT_MAX)) u_min_tens (
    .clk(clk), .rst(rst), .clr(clr), .inc(mo_carry), .term_ovr(min_term),
    .q(min_tens), .carry(mt_carry)
  );

  assign sec_tick = tick_q;
  assign rollover = rollover_q;

endmodule

// File: tb/tb_mmss_seconds_counter.sv
// Scoreboard bench: a seconds-count model predicts every cycle for MIN_MODULUS 60 and 2.
module tb_mmss_seconds_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sec_wave = 1'b1;
  logic run = 1'b0;
  logic clr = 1'b0;

  logic [3:0] a_so, a_st, a_mo, a_mt;
  logic [3:0] b_so, b_st, b_mo, b_mt;
  logic       a_tick, a_roll, b_tick, b_roll;

  typedef struct packed {
    logic [17:0] a;
    logic [17:0] b;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int passes = 0;
  int m_cnt[2];
  int m_mod[2] = '{60, 2};
  logic m_wq = 1'b1;
  int a_ticks = 0;
  int a_rolls = 0;
  int b_rolls = 0;

  always #5 clk = ~clk;

  mmss_seconds_counter #(.MIN_MODULUS(60)) dut_a (
    .clk(clk), .rst(rst), .sec_wave(sec_wave), .run(run), .clr(clr),
    .sec_ones(a_so), .sec_tens(a_st), .min_ones(a_mo), .min_tens(a_mt),
    .sec_tick(a_tick), .rollover(a_roll)
  );

  mmss_seconds_counter #(.MIN_MODULUS(2)) dut_b (
    .clk(clk), .rst(rst), .sec_wave(sec_wave), .run(run), .clr(clr),
    .sec_ones(b_so), .sec_tens(b_st), .min_ones(b_mo), .min_tens(b_mt),
    .sec_tick(b_tick), .rollover(b_roll)
  );

  function automatic logic [17:0] pack_exp(input int cnt, input logic t, input logic r);
    int m;
    int s;
    m = cnt / 60;
    s = cnt % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), t, r};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s at %0t: observed=%h expected=%h", tag, $time, observed, expected);
    end else begin
      passes++;
    end
  endtask

  // Model the current inputs, push the prediction, clock once, then compare.
  task automatic apply_stimulus(input logic w);
    logic m_edge;
    logic e_tick;
    logic e_roll[2];
    exp_t e;
    exp_t got;
    sec_wave = w;
    e_tick = 1'b0;
    e_roll[0] = 1'b0;
    e_roll[1] = 1'b0;
    if (rst) begin
      m_wq = 1'b1;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
    end else begin
      m_edge = sec_wave & ~m_wq;
      m_wq = sec_wave;
      for (int k = 0; k < 2; k++) begin
        if (clr) begin
          m_cnt[k] = 0;
        end else if (m_edge && run) begin
          e_tick = 1'b1;
          e_roll[k] = (m_cnt[k] == m_mod[k] * 60 - 1);
          m_cnt[k] = e_roll[k] ? 0 : m_cnt[k] + 1;
        end
      end
    end
    e.a = pack_exp(m_cnt[0], e_tick, e_roll[0]);
    e.b = pack_exp(m_cnt[1], e_tick, e_roll[1]);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    got.a = {a_mt, a_mo, a_st, a_so, a_tick, a_roll};
    got.b = {b_mt, b_mo, b_st, b_so, b_tick, b_roll};
    check_output("cycle_mod60", 32'(got.a), 32'(e.a));
    check_output("cycle_mod2", 32'(got.b), 32'(e.b));
    a_ticks += int'(a_tick);
    a_rolls += int'(a_roll);
    b_rolls += int'(b_roll);
  endtask

  task automatic edges(input int n, input int half);
    for (int i = 0; i < n; i++) begin
      repeat (half) apply_stimulus(1'b0);
      repeat (half) apply_stimulus(1'b1);
    end
  endtask

  function automatic logic [31:0] digits_a();
    return {16'h0, a_mt, a_mo, a_st, a_so};
  endfunction

  initial begin
    // Reset with the wave already high, then run while it stays high.
    rst = 1'b1;
    repeat (3) apply_stimulus(1'b1);
    rst = 1'b0;
    run = 1'b1;
    repeat (10) apply_stimulus(1'b1);
    check_output("hold_high_digits", digits_a(), 32'h0000);
    check_output("hold_high_ticks", 32'(a_ticks), 32'd0);

    edges(10, 10);
    check_output("ten_edges_digits", digits_a(), 32'h0010);
    check_output("ten_edges_ticks", 32'(a_ticks), 32'd10);

    edges(49, 2);
    check_output("preload_0059", digits_a(), 32'h0059);
    edges(1, 2);
    check_output("carry_0100", digits_a(), 32'h0100);

    edges(3539, 2);
    check_output("reach_5959", digits_a(), 32'h5959);
    check_output("mod2_at_0159", 32'({b_mt, b_mo, b_st, b_so}), 32'h0159);
    check_output("no_roll_yet", 32'(a_rolls), 32'd0);
    edges(1, 2);
    check_output("wrap_0000", digits_a(), 32'h0000);
    check_output("wrap_rollovers", 32'(a_rolls), 32'd1);
    check_output("mod2_rollovers", 32'(b_rolls), 32'd30);

    // Paused edges are dropped; resuming while high must not count.
    edges(3, 2);
    run = 1'b0;
    edges(5, 2);
    check_output("paused_frozen", digits_a(), 32'h0003);
    repeat (2) apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    run = 1'b1;
    repeat (4) apply_stimulus(1'b1);
    check_output("resume_high", digits_a(), 32'h0003);
    edges(1, 2);
    check_output("resume_edge", digits_a(), 32'h0004);

    edges(38, 2);
    check_output("reach_0042", digits_a(), 32'h0042);
    repeat (2) apply_stimulus(1'b0);
    clr = 1'b1;
    apply_stimulus(1'b1);
    check_output("clr_tick_low", 32'(a_tick), 32'd0);
    clr = 1'b0;
    repeat (3) apply_stimulus(1'b1);
    check_output("clr_digits", digits_a(), 32'h0000);

    edges(754, 2);
    check_output("reach_1234", digits_a(), 32'h1234);
    rst = 1'b1;
    apply_stimulus(1'b1);
    check_output("rst_mid_count", digits_a(), 32'h0000);
    rst = 1'b0;
    repeat (3) apply_stimulus(1'b1);
    check_output("after_rst_high", digits_a(), 32'h0000);
    edges(1, 2);
    check_output("after_rst_edge", digits_a(), 32'h0001);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
